periph_timer: RTL and testbench

Memory-mapped peripheral responder that answers the pipeline's MEM-stage load/store bus (Address, Write_data, MemRead, MemWrite → Read_data). It holds a reloadable 32-bit interval timer with a sticky interrupt, a free-running systick counter, and the LED and 7-segment digit registers that software writes. It sits beside the data memory in the MEM stage and is selected by address decode in the 0x4000_0000 page.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/timer_core.sv | 80 ++++++++
 rtl/periph_timer.sv | 83 ++++++++
 tb/tb_periph_timer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants for the MEM-stage peripheral window: base address,
// register byte offsets and TCON bit positions.
package pipeline_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

  localparam logic [31:0] OFF_TH      = 32'h0000_0000;
  localparam logic [31:0] OFF_TL      = 32'h0000_0004;
  localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
  localparam logic [31:0] OFF_LED     = 32'h0000_000C;
  localparam logic [31:0] OFF_DIGI    = 32'h0000_0010;
  localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IF = 2;

endpackage

// File: rtl/timer_core.sv
// Reloadable 32-bit interval timer: prescaler, TH/TL, TCON and the sticky
// overflow flag. Bus writes arrive as one-cycle write enables.
module timer_core
  import pipeline_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        th_we,
  input  logic        tl_we,
  input  logic        tcon_we,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

  logic [15:0] pcnt;
  logic        en;
  logic        ie;
  logic        if_flag;
  logic        tick;
  logic        ovf;

  assign tick = en && (pcnt == PRESCALE_MAX);
  assign ovf  = tick && (tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (!en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 16'd1;
    end
  end

  // A store to TL beats the advance; the reload always uses the TH value
  // held before this edge, so a same-cycle TH store only affects later reloads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      th <= '0;
      tl <= '0;
    end else begin
      if (th_we) th <= wdata;
      if (tl_we)     tl <= wdata;
      else if (ovf)  tl <= th;
      else if (tick) tl <= tl + 32'd1;
    end
  end

  // IF is sticky: an overflow in the same cycle as a TCON store still sets it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en      <= 1'b0;
      ie      <= 1'b0;
      if_flag <= 1'b0;
    end else if (tcon_we) begin
      en      <= wdata[TCON_EN];
      ie      <= wdata[TCON_IE];
      if_flag <= wdata[TCON_IF] | ovf;
    end else if (ovf) begin
      if_flag <= 1'b1;
    end
  end

  always_comb begin
    tcon          = '0;
    tcon[TCON_EN] = en;
    tcon[TCON_IE] = ie;
    tcon[TCON_IF] = if_flag;
  end

  assign irq = ie & if_flag;

endmodule

// File: rtl/periph_timer.sv
// MEM-stage peripheral responder: address decode, read mux, SYSTICK and the
// LED/DIGI output registers around timer_core.
module periph_timer
  import pipeline_pkg::*;
#(
  parameter int          PRESCALE = 1,
  parameter logic [31:0] BASE     = PERIPH_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        hit,
  output logic        irq,
  output logic [7:0]  led,
  output logic [11:0] digi
);

  // Bus semantics: MemRead/MemWrite are single-cycle strobes with no stall;
  // a store commits on the next clk edge, a load is answered combinationally.
  logic [31:0] off;
  logic [31:0] reg_off;
  logic        we;
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;
  logic [31:0] rdata_mux;

  assign off     = Address - BASE;
  assign reg_off = {off[31:2], 2'b00};
  assign hit     = (reg_off <= OFF_SYSTICK);
  assign we      = MemWrite && hit;

  timer_core #(
    .PRESCALE(PRESCALE)
  ) u_timer_core (
    .clk    (clk),
    .reset  (reset),
    .th_we  (we && (reg_off == OFF_TH)),
    .tl_we  (we && (reg_off == OFF_TL)),
    .tcon_we(we && (reg_off == OFF_TCON)),
    .wdata  (Write_data),
    .th     (th),
    .tl     (tl),
    .tcon   (tcon),
    .irq    (irq)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      led  <= '0;
      digi <= '0;
    end else begin
      if (we && (reg_off == OFF_LED))  led  <= Write_data[7:0];
      if (we && (reg_off == OFF_DIGI)) digi <= Write_data[11:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) systick <= '0;
    else        systick <= systick + 32'd1;
  end

  always_comb begin
    rdata_mux = '0;
    case (reg_off)
      OFF_TH:      rdata_mux = th;
      OFF_TL:      rdata_mux = tl;
      OFF_TCON:    rdata_mux = {29'd0, tcon};
      OFF_LED:     rdata_mux = {24'd0, led};
      OFF_DIGI:    rdata_mux = {20'd0, digi};
      OFF_SYSTICK: rdata_mux = systick;
      default:     rdata_mux = '0;
    endcase
  end

  assign Read_data = (MemRead && hit) ? rdata_mux : 32'd0;

endmodule

// File: tb/tb_periph_timer.sv
// Directed bench for periph_timer: one instance at PRESCALE=1, one at
// PRESCALE=4, both sharing the bus inputs.
module tb_periph_timer;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] rdata1, rdata4;
  logic        hit1, hit4;
  logic        irq1, irq4;
  logic [7:0]  led1, led4;
  logic [11:0] digi1, digi4;

  int vectors;
  int miscompares;
  logic [31:0] exp_tick;

  periph_timer #(.PRESCALE(1), .BASE(B)) dut (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(rdata1),
    .hit(hit1), .irq(irq1), .led(led1), .digi(digi1)
  );

  periph_timer #(.PRESCALE(4), .BASE(B)) dut4 (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(rdata4),
    .hit(hit4), .irq(irq4), .led(led4), .digi(digi4)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // bench-side SYSTICK model
  always @(posedge clk) begin
    if (!reset) exp_tick <= 32'd0;
    else        exp_tick <= exp_tick + 32'd1;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address    = a;
    Write_data = d;
    MemWrite   = 1'b1;
    @(posedge clk);
    #1;
    MemWrite   = 1'b0;
    Write_data = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d1, output logic [31:0] d4);
    Address = a;
    MemRead = 1'b1;
    #1;
    d1 = rdata1;
    d4 = rdata4;
    MemRead = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d1, d4;
    reset = 1'b0;
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      rd(B + 32'(i * 4), d1, d4);
      vectors++;
      if (d1 !== 32'd0 || d4 !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_read off=%0h got %h/%h want 0", i * 4, d1, d4);
      end
      vectors++;
      if (hit1 !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_hit off=%0h got %b want 1", i * 4, hit1);
      end
    end
    Address = B + 32'h18;
    #1;
    vectors++;
    if (hit1 !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_unmapped got %b want 0", hit1);
    end
    vectors++;
    if ({irq1, irq4, led1, digi1} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got irq=%b led=%h digi=%h want 0", irq1, led1, digi1);
    end
    reset = 1'b1;
  endtask

  task automatic test_reload();
    logic [31:0] d1, d4;
    wr(B + 32'h00, 32'hFFFF_FFF0);
    wr(B + 32'h04, 32'hFFFF_FFFE);
    wr(B + 32'h08, 32'd3);
    step();
    vectors++;
    rd(B + 32'h04, d1, d4);
    if (d1 !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL reload_edge1_tl got %h want ffffffff", d1);
    end
    step();
    rd(B + 32'h04, d1, d4);
    vectors++;
    if (d1 !== 32'hFFFF_FFF0) begin
      miscompares++;
      $display("FAIL reload_tl got %h want fffffff0", d1);
    end
    rd(B + 32'h08, d1, d4);
    vectors++;
    if (d1 !== 32'd7 || irq1 !== 1'b1) begin
      miscompares++;
      $display("FAIL reload_tcon_irq got tcon=%h irq=%b want 7/1", d1, irq1);
    end
    wr(B + 32'h08, 32'd3);
    rd(B + 32'h08, d1, d4);
    vectors++;
    if (d1 !== 32'd3 || irq1 !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_if got tcon=%h irq=%b want 3/0", d1, irq1);
    end
    wr(B + 32'h08, 32'd0);
  endtask

  task automatic test_ie_mask();
    logic [31:0] d1, d4;
    wr(B + 32'h04, 32'hFFFF_FFFF);
    wr(B + 32'h08, 32'd1);
    step();
    rd(B + 32'h08, d1, d4);
    vectors++;
    if (d1 !== 32'd5 || irq1 !== 1'b0) begin
      miscompares++;
      $display("FAIL ie_masked got tcon=%h irq=%b want 5/0", d1, irq1);
    end
    wr(B + 32'h08, 32'd7);
    vectors++;
    if (irq1 !== 1'b1) begin
      miscompares++;
      $display("FAIL ie_unmask got irq=%b want 1", irq1);
    end
    wr(B + 32'h08, 32'd0);
  endtask

  task automatic test_collision();
    logic [31:0] d1, d4;
    wr(B + 32'h04, 32'hFFFF_FFFE);
    wr(B + 32'h08, 32'd1);
    step();
    wr(B + 32'h08, 32'd3);
    rd(B + 32'h08, d1, d4);
    vectors++;
    if (d1 !== 32'd7 || irq1 !== 1'b1) begin
      miscompares++;
      $display("FAIL tcon_vs_ovf got tcon=%h irq=%b want 7/1", d1, irq1);
    end
    wr(B + 32'h04, 32'hFFFF_FFFF);
    wr(B + 32'h00, 32'h0000_0055);
    rd(B + 32'h04, d1, d4);
    vectors++;
    if (d1 !== 32'hFFFF_FFF0) begin
      miscompares++;
      $display("FAIL th_vs_ovf_tl got %h want fffffff0", d1);
    end
    rd(B + 32'h00, d1, d4);
    vectors++;
    if (d1 !== 32'h0000_0055) begin
      miscompares++;
      $display("FAIL th_vs_ovf_th got %h want 00000055", d1);
    end
    wr(B + 32'h04, 32'h0000_0010);
    rd(B + 32'h04, d1, d4);
    vectors++;
    if (d1 !== 32'h0000_0010) begin
      miscompares++;
      $display("FAIL tl_vs_advance got %h want 00000010", d1);
    end
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] d1, d4;
    wr(B + 32'h08, 32'd7);
    reset = 1'b0;
    step();
    reset = 1'b1;
    rd(B + 32'h08, d1, d4);
    vectors++;
    if (d1 !== 32'd0 || irq1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_tcon got tcon=%h irq=%b want 0/0", d1, irq1);
    end
    rd(B + 32'h04, d1, d4);
    vectors++;
    if (d1 !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_tl got %h want 0", d1);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] d1, d4;
    do_reset();
    wr(B + 32'h04, 32'd0);
    wr(B + 32'h08, 32'd1);
    step();
    step();
    step();
    rd(B + 32'h04, d1, d4);
    vectors++;
    if (d4 !== 32'd0) begin
      miscompares++;
      $display("FAIL prescale_3 got %h want 0", d4);
    end
    step();
    rd(B + 32'h04, d1, d4);
    vectors++;
    if (d4 !== 32'd1) begin
      miscompares++;
      $display("FAIL prescale_4 got %h want 1", d4);
    end
    for (int i = 0; i < 4; i++) step();
    rd(B + 32'h04, d1, d4);
    vectors++;
    if (d4 !== 32'd2) begin
      miscompares++;
      $display("FAIL prescale_8 got %h want 2", d4);
    end
    wr(B + 32'h08, 32'd0);
    for (int i = 0; i < 8; i++) step();
    rd(B + 32'h04, d1, d4);
    vectors++;
    if (d4 !== 32'd2) begin
      miscompares++;
      $display("FAIL prescale_frozen got %h want 2", d4);
    end
  endtask

  task automatic test_bus();
    logic [31:0] d1, d4;
    wr(B + 32'h0C, 32'h0000_01A5);
    rd(B + 32'h0C, d1, d4);
    vectors++;
    if (led1 !== 8'hA5 || d1 !== 32'h0000_00A5) begin
      miscompares++;
      $display("FAIL led got led=%h rd=%h want a5/000000a5", led1, d1);
    end
    wr(B + 32'h10, 32'hFFFF_F3C6);
    rd(B + 32'h12, d1, d4);
    vectors++;
    if (digi1 !== 12'h3C6 || d1 !== 32'h0000_03C6) begin
      miscompares++;
      $display("FAIL digi got digi=%h rd=%h want 3c6/000003c6", digi1, d1);
    end
    wr(B + 32'h14, 32'd5);
    step();
    rd(B + 32'h14, d1, d4);
    vectors++;
    if (d1 !== exp_tick) begin
      miscompares++;
      $display("FAIL systick got %h want %h", d1, exp_tick);
    end
    wr(B + 32'h18, 32'hFFFF_FFFF);
    rd(B + 32'h18, d1, d4);
    vectors++;
    if (d1 !== 32'd0 || led1 !== 8'hA5) begin
      miscompares++;
      $display("FAIL unmapped got rd=%h led=%h want 0/a5", d1, led1);
    end
    Address = B + 32'h0C;
    MemRead = 1'b0;
    #1;
    vectors++;
    if (rdata1 !== 32'd0) begin
      miscompares++;
      $display("FAIL no_memread got %h want 0", rdata1);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    Address     = 32'd0;
    Write_data  = 32'd0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    test_reset();
    test_reload();
    test_ie_mask();
    test_collision();
    test_reset_mid_count();
    test_prescale();
    test_bus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
